// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL-lock driven core reset sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_SW_RST    = 2'd3
  } pll_state_e;

  localparam int unsigned DEF_SYNC_STAGES      = 32'd2;
  localparam int unsigned DEF_LOCK_HOLD_CYCLES = 32'd1024;
  localparam int unsigned DEF_LOSS_FILTER      = 32'd4;
  localparam int unsigned DEF_SW_RST_CYCLES    = 32'd16;
  localparam int unsigned DEF_CNT_W            = 32'd8;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic multi-flop synchronizer for a single asynchronous level signal.
module bit_sync #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock is qualified; re-asserts on filtered
// lock loss or software request, and counts lock-loss events.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_HOLD_CYCLES = DEF_LOCK_HOLD_CYCLES,
  parameter int unsigned LOSS_FILTER      = DEF_LOSS_FILTER,
  parameter int unsigned SW_RST_CYCLES    = DEF_SW_RST_CYCLES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_in,
  input  logic             sw_reset_req,
  output logic             sys_rst_n,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [1:0]       state
);

  localparam int unsigned HOLD_W = cnt_width(LOCK_HOLD_CYCLES);
  localparam int unsigned LOSS_W = cnt_width(LOSS_FILTER);
  localparam int unsigned SW_W   = cnt_width(SW_RST_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD_CYCLES - 32'd1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 32'd1);
  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic              lock_sync_s;
  pll_state_e        state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [LOSS_W-1:0] loss_cnt_r;
  logic [SW_W-1:0]   sw_cnt_r;
  logic              sys_rst_n_r;
  logic              lock_lost_r;
  logic [CNT_W-1:0]  lock_lost_cnt_r;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked_in),
    .q     (lock_sync_s)
  );

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_WAIT_LOCK;
      hold_cnt_r      <= '0;
      loss_cnt_r      <= '0;
      sw_cnt_r        <= '0;
      sys_rst_n_r     <= 1'b0;
      lock_lost_r     <= 1'b0;
      lock_lost_cnt_r <= '0;
    end else begin
      lock_lost_r <= 1'b0;
      case (state_r)
        ST_WAIT_LOCK: begin
          sys_rst_n_r <= 1'b0;
          hold_cnt_r  <= '0;
          loss_cnt_r  <= '0;
          sw_cnt_r    <= '0;
          if (lock_sync_s) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_WAIT_LOCK;
          end
        end
        ST_HOLD: begin
          loss_cnt_r <= '0;
          sw_cnt_r   <= '0;
          if (!lock_sync_s) begin
            state_r     <= ST_WAIT_LOCK;
            hold_cnt_r  <= '0;
            sys_rst_n_r <= 1'b0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r     <= ST_RUN;
            hold_cnt_r  <= '0;
            sys_rst_n_r <= 1'b1;
          end else begin
            hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
            sys_rst_n_r <= 1'b0;
          end
        end
        ST_RUN, ST_SW_RST: begin
          hold_cnt_r <= '0;
          // The loss filter runs in both states and outranks any sw request.
          if (!lock_sync_s && (loss_cnt_r == LOSS_LAST)) begin
            state_r     <= ST_WAIT_LOCK;
            sys_rst_n_r <= 1'b0;
            lock_lost_r <= 1'b1;
            loss_cnt_r  <= '0;
            sw_cnt_r    <= '0;
            if (lock_lost_cnt_r != CNT_MAX) begin
              lock_lost_cnt_r <= lock_lost_cnt_r + CNT_W'(1);
            end else begin
              lock_lost_cnt_r <= lock_lost_cnt_r;
            end
          end else begin
            if (lock_sync_s) begin
              loss_cnt_r <= '0;
            end else begin
              loss_cnt_r <= loss_cnt_r + LOSS_W'(1);
            end
            if (state_r == ST_RUN) begin
              if (sw_reset_req) begin
                state_r     <= ST_SW_RST;
                sw_cnt_r    <= '0;
                sys_rst_n_r <= 1'b0;
              end else begin
                state_r     <= ST_RUN;
                sys_rst_n_r <= 1'b1;
              end
            end else if (sw_cnt_r == SW_LAST) begin
              state_r     <= ST_WAIT_LOCK;
              sw_cnt_r    <= '0;
              sys_rst_n_r <= 1'b0;
            end else begin
              sw_cnt_r    <= sw_cnt_r + SW_W'(1);
              sys_rst_n_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_WAIT_LOCK;
          hold_cnt_r  <= '0;
          loss_cnt_r  <= '0;
          sw_cnt_r    <= '0;
          sys_rst_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign sys_rst_n     = sys_rst_n_r;
  assign lock_lost     = lock_lost_r;
  assign lock_lost_cnt = lock_lost_cnt_r;
  assign state         = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: default instance plus a fast-cycling
// instance used to drive the lock-loss counter into saturation.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       locked_in;
  logic       sw_reset_req;
  logic       sys_rst_n;
  logic       lock_lost;
  logic [7:0] lock_lost_cnt;
  logic [1:0] state;

  logic       locked_in2;
  logic       sw_reset_req2;
  logic       sys_rst_n2;
  logic       lock_lost2;
  logic [7:0] lock_lost_cnt2;
  logic [1:0] state2;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked_in     (locked_in),
    .sw_reset_req  (sw_reset_req),
    .sys_rst_n     (sys_rst_n),
    .lock_lost     (lock_lost),
    .lock_lost_cnt (lock_lost_cnt),
    .state         (state)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES      (2),
    .LOCK_HOLD_CYCLES (1),
    .LOSS_FILTER      (1),
    .SW_RST_CYCLES    (1),
    .CNT_W            (8)
  ) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked_in     (locked_in2),
    .sw_reset_req  (sw_reset_req2),
    .sys_rst_n     (sys_rst_n2),
    .lock_lost     (lock_lost2),
    .lock_lost_cnt (lock_lost_cnt2),
    .state         (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise lock from a clean WAIT_LOCK; the next edge is edge 1, release at 1027.
  task automatic relock_run(input string tag);
    logic early_ok;
    early_ok  = 1'b1;
    locked_in = 1'b1;
    for (int e = 1; e <= 1027; e++) begin
      tick();
      if (e <= 1026 && sys_rst_n !== 1'b0) early_ok = 1'b0;
      if (e == 2)    check_eq({tag, "_state_e2"}, 32'(state), 32'd0);
      if (e == 3)    check_eq({tag, "_state_e3"}, 32'(state), 32'd1);
      if (e == 1026) check_eq({tag, "_state_e1026"}, 32'(state), 32'd1);
      if (e == 1027) begin
        check_eq({tag, "_rst_e1027"}, 32'(sys_rst_n), 32'd1);
        check_eq({tag, "_state_e1027"}, 32'(state), 32'd2);
      end
    end
    check_eq({tag, "_rst_low_until_1026"}, 32'(early_ok), 32'd1);
  endtask

  initial begin
    logic ok;
    logic found;
    int   losses;

    rst_n         = 1'b0;
    locked_in     = 1'b0;
    sw_reset_req  = 1'b0;
    locked_in2    = 1'b0;
    sw_reset_req2 = 1'b0;
    repeat (5) tick();
    check_eq("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check_eq("reset_lock_lost", 32'(lock_lost), 32'd0);
    check_eq("reset_cnt", 32'(lock_lost_cnt), 32'd0);
    check_eq("reset_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick();

    relock_run("pwr");
    check_eq("pwr_cnt", 32'(lock_lost_cnt), 32'd0);

    // 3-cycle glitch is filtered
    ok = 1'b1;
    locked_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) locked_in = 1'b1;
      if (sys_rst_n !== 1'b1 || lock_lost !== 1'b0) ok = 1'b0;
    end
    check_eq("glitch3_no_effect", 32'(ok), 32'd1);
    check_eq("glitch3_state", 32'(state), 32'd2);

    // 4-cycle drop is a declared loss at edge 6
    locked_in = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    locked_in = 1'b1;
    tick();
    check_eq("loss4_rst_e5", 32'(sys_rst_n), 32'd1);
    check_eq("loss4_lost_e5", 32'(lock_lost), 32'd0);
    tick();
    check_eq("loss4_rst_e6", 32'(sys_rst_n), 32'd0);
    check_eq("loss4_lost_e6", 32'(lock_lost), 32'd1);
    check_eq("loss4_state_e6", 32'(state), 32'd0);
    check_eq("loss4_cnt_e6", 32'(lock_lost_cnt), 32'd1);
    tick();
    check_eq("loss4_lost_e7", 32'(lock_lost), 32'd0);
    check_eq("loss4_state_e7", 32'(state), 32'd1);

    // Lock drop in HOLD at hold_cnt=500
    repeat (500) tick();
    check_eq("hold500_state", 32'(state), 32'd1);
    locked_in = 1'b0;
    repeat (2) tick();
    check_eq("holddrop_state_still_hold", 32'(state), 32'd1);
    tick();
    check_eq("holddrop_state", 32'(state), 32'd0);
    check_eq("holddrop_cnt", 32'(lock_lost_cnt), 32'd1);
    check_eq("holddrop_lost", 32'(lock_lost), 32'd0);
    repeat (3) tick();
    relock_run("relock");

    // Software reset; a request during the following HOLD is ignored
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check_eq("sw_state_e0", 32'(state), 32'd3);
    check_eq("sw_rst_e0", 32'(sys_rst_n), 32'd0);
    ok = 1'b1;
    for (int e = 1; e <= 1041; e++) begin
      if (e == 100) sw_reset_req = 1'b1;
      tick();
      if (e == 100) sw_reset_req = 1'b0;
      if (e <= 1040 && sys_rst_n !== 1'b0) ok = 1'b0;
      if (e == 15)   check_eq("sw_state_e15", 32'(state), 32'd3);
      if (e == 16)   check_eq("sw_state_e16", 32'(state), 32'd0);
      if (e == 17)   check_eq("sw_state_e17", 32'(state), 32'd1);
      if (e == 101)  check_eq("sw_hold_req_ignored", 32'(state), 32'd1);
      if (e == 1041) begin
        check_eq("sw_release_rst", 32'(sys_rst_n), 32'd1);
        check_eq("sw_release_state", 32'(state), 32'd2);
      end
    end
    check_eq("sw_rst_low_window", 32'(ok), 32'd1);

    // Loss declaration and sw request in the same cycle
    locked_in = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check_eq("simul_state", 32'(state), 32'd0);
    check_eq("simul_lost", 32'(lock_lost), 32'd1);
    check_eq("simul_cnt", 32'(lock_lost_cnt), 32'd2);
    check_eq("simul_rst", 32'(sys_rst_n), 32'd0);
    repeat (3) tick();

    // Async reset mid-HOLD
    locked_in = 1'b1;
    repeat (200) tick();
    check_eq("ahold_state_before", 32'(state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ahold_rst", 32'(sys_rst_n), 32'd0);
    check_eq("ahold_state", 32'(state), 32'd0);
    check_eq("ahold_cnt", 32'(lock_lost_cnt), 32'd0);
    locked_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    relock_run("after_hold_rst");

    // Async reset mid-RUN
    repeat (5) tick();
    check_eq("arun_rst_before", 32'(sys_rst_n), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arun_rst", 32'(sys_rst_n), 32'd0);
    check_eq("arun_state", 32'(state), 32'd0);
    check_eq("arun_lost", 32'(lock_lost), 32'd0);
    locked_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    relock_run("after_run_rst");

    // 300 losses on the fast instance saturate its counter at 255
    losses = 0;
    for (int i = 0; i < 300; i++) begin
      locked_in2 = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        tick();
        if (state2 == 2'd2) found = 1'b1;
      end
      if (!found) check_eq("sat_reach_run_timeout", 32'(found), 32'd1);
      locked_in2 = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        tick();
        if (lock_lost2 == 1'b1) found = 1'b1;
      end
      if (!found) check_eq("sat_loss_timeout", 32'(found), 32'd1);
      else losses++;
      if (i == 99)  check_eq("sat_cnt_100", 32'(lock_lost_cnt2), 32'd100);
      if (i == 254) check_eq("sat_cnt_255", 32'(lock_lost_cnt2), 32'd255);
    end
    check_eq("sat_losses_seen", 32'(losses), 32'd300);
    check_eq("sat_cnt_final", 32'(lock_lost_cnt2), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
